// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 constants, field layout and operand classes
package fp_pkg;

    localparam int          FP32_BIAS    = 127;
    localparam int          FP32_EXP_MAX = 255;
    localparam logic [31:0] FP32_ZERO    = 32'h0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF_NAN
    } fp_class_t;

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - split a binary32 word into fields and classify it
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [31:0] word,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] sig,
    output fp_class_t   cls
);

    fp32_t f;

    assign f    = word;
    assign sign = f.sign;
    assign exp  = f.exp;
    // Hidden bit is always set; zero/denormal operands never reach the packer.
    assign sig  = {1'b1, f.frac};

    // Denormals share the zero class because they are flushed to zero.
    always_comb begin
        cls = FP_NORM;
        if (f.exp == 8'h00)
            cls = FP_ZERO;
        else if (f.exp == 8'(FP32_EXP_MAX))
            cls = FP_INF_NAN;
    end

endmodule

// File: rtl/mul.sv
// rtl/mul.sv - two-stage binary32 multiplier with truncation and exception flag
module mul
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] M1,
    input  logic [31:0] M2,
    output logic        out_valid,
    output logic [31:0] P,
    output logic        EX
);

    localparam logic signed [9:0] EXP_MAX_S = 10'(FP32_EXP_MAX);
    localparam logic signed [9:0] BIAS_S    = 10'(FP32_BIAS);

    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_sig, b_sig;
    fp_class_t   a_cls, b_cls;

    fp32_unpack u_unpack_a (.word(M1), .sign(a_sign), .exp(a_exp), .sig(a_sig), .cls(a_cls));
    fp32_unpack u_unpack_b (.word(M2), .sign(b_sign), .exp(b_exp), .sig(b_sig), .cls(b_cls));

    // Stage 1 combinational terms. Only product bits [47:23] feed the
    // truncating normaliser, so the low bits are never registered.
    logic signed [9:0] exp_sum_d;
    logic [24:0]       prod_hi_d;
    logic              any_inf_d, any_zero_d;

    assign exp_sum_d  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
    assign prod_hi_d  = 25'(({24'b0, a_sig} * {24'b0, b_sig}) >> 23);
    assign any_inf_d  = (a_cls == FP_INF_NAN) || (b_cls == FP_INF_NAN);
    assign any_zero_d = (a_cls == FP_ZERO) || (b_cls == FP_ZERO);

    logic              s1_valid;
    logic              s1_sign;
    logic signed [9:0] s1_exp_sum;
    logic [24:0]       s1_prod_hi;
    logic              s1_any_inf;
    logic              s1_any_zero;

    // Stage 1 register: the cleared state reads as a zero operand so the
    // second stage produces +0 with no exception straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_exp_sum  <= '0;
            s1_prod_hi  <= '0;
            s1_any_inf  <= 1'b0;
            s1_any_zero <= 1'b1;
        end else begin
            s1_valid    <= in_valid;
            s1_sign     <= a_sign ^ b_sign;
            s1_exp_sum  <= exp_sum_d;
            s1_prod_hi  <= prod_hi_d;
            s1_any_inf  <= any_inf_d;
            s1_any_zero <= any_zero_d;
        end
    end

    // Stage 2 combinational: normalise, truncate, apply special-case priority.
    logic signed [9:0] exp_norm;
    logic [22:0]       mant;
    fp32_t             p_d;
    logic              ex_d;

    assign exp_norm = s1_exp_sum + $signed({9'b0, s1_prod_hi[24]});
    assign mant     = s1_prod_hi[24] ? s1_prod_hi[23:1] : s1_prod_hi[22:0];

    // Special cases in priority order; only the normal path packs fields.
    always_comb begin
        p_d  = FP32_ZERO;
        ex_d = 1'b0;
        if (s1_any_inf) begin
            ex_d = 1'b1;
        end else if (s1_any_zero) begin
            ex_d = 1'b0;
        end else if (exp_norm >= EXP_MAX_S) begin
            ex_d = 1'b1;
        end else if (exp_norm <= 10'sd0) begin
            ex_d = 1'b1;
        end else begin
            p_d.sign = s1_sign;
            p_d.exp  = exp_norm[7:0];
            p_d.frac = mant;
        end
    end

    // Stage 2 register: results update every cycle, valid tag rides alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            P         <= FP32_ZERO;
            EX        <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            P         <= p_d;
            EX        <= ex_d;
        end
    end

endmodule

// File: tb/tb_mul.sv
// tb/tb_mul.sv - randomized and directed self-checking bench for mul
module tb_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] M1 = '0;
    logic [31:0] M2 = '0;
    logic        out_valid;
    logic [31:0] P;
    logic        EX;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        v;
        logic [31:0] p;
        logic [31:0] mask;
        logic        ex;
    } exp_t;

    exp_t h0, h1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [31:0] mask;
        logic        ex;
    } dir_t;

    mul dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .M1(M1), .M2(M2),
        .out_valid(out_valid), .P(P), .EX(EX)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Reference: exact integer product of the significands, shifted down until
    // it fits in 24 bits; each shift beyond 23 adds one to the exponent.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p, output logic ex);
        int          ea, eb, e, sh;
        longint      prod, top;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        p  = 32'h0;
        ex = 1'b0;
        if (ea == 255 || eb == 255) begin
            ex = 1'b1;
        end else if (ea == 0 || eb == 0) begin
            ex = 1'b0;
        end else begin
            prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            sh = 0;
            while ((prod >> sh) >= (longint'(1) << 24)) sh++;
            top = prod >> sh;
            e = ea + eb - 127 + (sh - 23);
            if (e >= 255 || e <= 0) begin
                ex = 1'b1;
            end else begin
                p = {a[31] ^ b[31], 8'(e), 23'(top - (longint'(1) << 23))};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 10))
                                                     : 8'($urandom_range(245, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(h1.v));
        if (h1.v) begin
            check("P", P & h1.mask, h1.p);
            check("EX", 32'(EX), 32'(h1.ex));
        end
    endtask

    // One cycle: check what the pair driven two cycles ago produced, then drive.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p_want, input logic [31:0] mask, input logic ex_want);
        @(negedge clk);
        check_outputs();
        in_valid = v;
        M1 = a;
        M2 = b;
        h1 = h0;
        h0 = '{v, p_want, mask, ex_want};
    endtask

    task automatic model_step(input logic v, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        logic        ex;
        ref_mul(a, b, p, ex);
        step(v, a, b, p, 32'hFFFF_FFFF, ex);
    endtask

    dir_t dir[11];

    initial begin
        h0 = '{1'b0, 32'h0, 32'h0, 1'b0};
        h1 = h0;

        dir[0]  = '{32'h4234851F, 32'h427C851F, 32'h45000000, 32'hFF800000, 1'b0};
        dir[1]  = '{32'h4049999A, 32'hC1663D71, 32'hC2000000, 32'hFF800000, 1'b0};
        dir[2]  = '{32'hC1526666, 32'hC240A3D7, 32'h44000000, 32'hFF800000, 1'b0};
        dir[3]  = '{32'h45800000, 32'h45800000, 32'h4B800000, 32'hFFFFFFFF, 1'b0};
        dir[4]  = '{32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        dir[5]  = '{32'hC1526666, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        dir[6]  = '{32'h3ACA62C1, 32'h3ACA62C1, 32'h36000000, 32'hFF800000, 1'b0};
        dir[7]  = '{32'h7F800000, 32'h7F800000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        dir[8]  = '{32'h00800000, 32'h00180000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        dir[9]  = '{32'h00800000, 32'h00800000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        dir[10] = '{32'h7F000000, 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 1'b1};

        // Reset state while rst_n is held low
        #12;
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst P", P, 32'h0);
        check("rst EX", 32'(EX), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed pairs back-to-back, each checked against its constant and the model
        foreach (dir[i])
            step(1'b1, dir[i].a, dir[i].b, dir[i].p, dir[i].mask, dir[i].ex);
        foreach (dir[i])
            model_step(1'b1, dir[i].a, dir[i].b);
        model_step(1'b0, 32'h0, 32'h0);
        model_step(1'b0, 32'h0, 32'h0);

        // Eight-pair stream with an asynchronous reset after the fifth pair
        for (int i = 0; i < 5; i++)
            model_step(1'b1, rand_op(), rand_op());
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'h0);
        check("midrst P", P, 32'h0);
        check("midrst EX", 32'(EX), 32'h0);
        in_valid = 1'b0;
        h0 = '{1'b0, 32'h0, 32'h0, 1'b0};
        h1 = h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            model_step(1'b1, rand_op(), rand_op());

        // Random traffic with occasional bubbles
        for (int i = 0; i < 400; i++)
            model_step(($urandom_range(0, 3) != 0), rand_op(), rand_op());
        model_step(1'b0, 32'h0, 32'h0);
        model_step(1'b0, 32'h0, 32'h0);
        model_step(1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
